// File: rtl/stream_priority_encoder_if.sv
// Valid/ready bundle carried between a request source, the priority encoder
// and the select logic it feeds: one input stream and one output stream.
interface stream_priority_encoder_if #(
  parameter int N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
);
  logic         in_valid;
  logic         in_ready;
  logic         in_enable;
  logic [N-1:0] in_onehot;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_code;
  logic         out_any;
  logic         out_multi;

  modport slave (
    input  in_valid, in_enable, in_onehot, out_ready,
    output in_ready, out_valid, out_code, out_any, out_multi
  );

  modport master (
    output in_valid, in_enable, in_onehot, out_ready,
    input  in_ready, out_valid, out_code, out_any, out_multi
  );
endinterface

// File: rtl/stream_priority_encoder.sv
// Registered, flow-controlled priority encoder: each accepted request word is
// encoded (highest set index, any, multi) into a 2-entry FIFO; multi-hot words are counted.
module stream_priority_encoder #(
  parameter int N     = 4,
  parameter int CNT_W = 8,
  localparam int W    = (N > 1) ? $clog2(N) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  stream_priority_encoder_if.slave bus,
  input  logic                     err_clear,
  output logic [CNT_W-1:0]         err_count,
  output logic [1:0]               dbg_state
);

  // Handshake: a word moves on a rising edge only when valid and ready are
  // both high; valid never waits on ready, and in_ready is a pure flop output.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [W-1:0] code;
    logic         any;
    logic         multi;
  } entry_t;

  state_e           state_q, state_d;
  entry_t           head_q, head_d;
  entry_t           tail_q, tail_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] err_q, err_d;

  logic [N-1:0] masked;
  logic [N-1:0] masked_dec;
  entry_t       enc;
  logic         push;
  logic         pop;

  always_comb begin
    masked     = bus.in_enable ? bus.in_onehot : '0;
    masked_dec = masked - N'(1);
    enc.code   = '0;
    for (int i = 0; i < N; i++) begin
      if (masked[i]) enc.code = W'(i);
    end
    enc.any   = |masked;
    // Clearing the lowest set bit leaves something only if two or more were set.
    enc.multi = |(masked & masked_dec);
  end

  assign push = bus.in_valid & in_ready_q;
  assign pop  = out_valid_q & bus.out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          head_d  = enc;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d = enc;
        end else if (push) begin
          tail_d  = enc;
          state_d = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only a pop can move the buffer.
        if (pop) begin
          head_d  = tail_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != FULL);
  end

  always_comb begin
    err_d = err_q;
    if (err_clear) begin
      err_d = '0;
    end else if (push && enc.multi && (err_q != {CNT_W{1'b1}})) begin
      err_d = err_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      head_q      <= '0;
      tail_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_code  = head_q.code;
  assign bus.out_any   = head_q.any;
  assign bus.out_multi = head_q.multi;
  assign err_count     = err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_stream_priority_encoder.sv
// Bench for stream_priority_encoder: directed and random words, reference
// encodings queued on accept and popped by a monitor on each output transfer.
module tb_stream_priority_encoder;
  localparam int N     = 4;
  localparam int W     = 2;
  localparam int CNT_W = 2;
  localparam int EW    = W + 2;

  logic             clk;
  logic             rst_n;
  logic             err_clear;
  logic [CNT_W-1:0] err_count;
  logic [1:0]       dbg_state;

  stream_priority_encoder_if #(.N(N)) bus ();

  stream_priority_encoder #(.N(N), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .err_clear (err_clear),
    .err_count (err_count),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;
  logic [EW-1:0] exp_q[$];
  int  exp_err;
  bit  rand_phase;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: scan from the top bit down for the first request, count bits for multi.
  function automatic logic [EW-1:0] model(input bit en, input logic [N-1:0] word);
    logic [N-1:0] m;
    int hi;
    m  = en ? word : '0;
    hi = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (m[i]) begin
        hi = i;
        break;
      end
    end
    return {hi[W-1:0], (m != 0), ($countones(m) > 1)};
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input bit en, input logic [N-1:0] word, input bit clr);
    logic [EW-1:0] e;
    bit done;
    done          = 0;
    bus.in_valid  = 1'b1;
    bus.in_enable = en;
    bus.in_onehot = word;
    err_clear     = clr;
    for (int t = 0; t < 50 && !done; t++) begin
      if (bus.in_ready) begin
        e = model(en, word);
        exp_q.push_back(e);
        if (clr) exp_err = 0;
        else if (e[0] && exp_err < (1 << CNT_W) - 1) exp_err++;
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    err_clear    = 1'b0;
    if (!done) check("send_timeout", 0, 1);
    else check("err_count", err_count, exp_err);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic monitor();
    logic [EW-1:0] prev;
    logic [EW-1:0] cur;
    logic [EW-1:0] e;
    bit hold;
    hold = 0;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = {bus.out_code, bus.out_any, bus.out_multi};
      if (rst_n) begin
        if (hold && bus.out_valid) check("stall_stable", cur, prev);
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_output", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("out_code", bus.out_code, e[EW-1:2]);
            check("out_any", bus.out_any, e[1]);
            check("out_multi", bus.out_multi, e[0]);
          end
        end
      end
      hold = rst_n && bus.out_valid && !bus.out_ready;
      prev = cur;
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    exp_err       = 0;
    rand_phase    = 0;
    rst_n         = 1'b0;
    err_clear     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_enable = 1'b1;
    bus.in_onehot = '0;
    bus.out_ready = 1'b1;
    fork
      monitor();
    join_none

    #1;
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out_code", bus.out_code, 0);
    check("reset_out_any", bus.out_any, 0);
    check("reset_out_multi", bus.out_multi, 0);
    check("reset_err_count", err_count, 0);
    #20;
    rst_n = 1'b1;
    idle(1);
    check("ready_after_reset", bus.in_ready, 1);

    // Single one-hot words, one-cycle latency.
    for (int i = 0; i < N; i++) begin
      send(1'b1, N'(1) << i, 1'b0);
      check("latency_valid", bus.out_valid, 1);
    end
    idle(2);

    // Disabled and all-zero words still produce results.
    send(1'b0, 4'b0100, 1'b0);
    check("disabled_valid", bus.out_valid, 1);
    send(1'b1, 4'b0000, 1'b0);
    check("zero_valid", bus.out_valid, 1);
    check("zero_err", err_count, 0);
    idle(2);

    // Multi-hot priority and clear.
    send(1'b1, 4'b0110, 1'b0);
    send(1'b1, 4'b1011, 1'b0);
    check("multi_err_two", err_count, 2);
    send(1'b1, 4'b1100, 1'b1);
    check("clear_priority", err_count, 0);
    idle(2);

    // Backpressure: two words fill the buffer, third waits.
    bus.out_ready = 1'b0;
    send(1'b1, 4'b0001, 1'b0);
    send(1'b1, 4'b0010, 1'b0);
    check("full_in_ready", bus.in_ready, 0);
    check("full_state", dbg_state, 2);
    fork
      send(1'b1, 4'b1000, 1'b0);
      begin
        idle(3);
        check("stall_code", bus.out_code, 0);
        bus.out_ready = 1'b1;
      end
    join
    idle(4);
    check("bp_drained", exp_q.size(), 0);

    // Saturation at 3 with a 2-bit counter.
    for (int i = 0; i < 5; i++) send(1'b1, 4'b0011 << (i % 3), 1'b0);
    check("saturated", err_count, 3);
    idle(3);

    // Async reset with a full buffer discards everything.
    bus.out_ready = 1'b0;
    send(1'b1, 4'b0010, 1'b0);
    send(1'b1, 4'b0100, 1'b0);
    rst_n = 1'b0;
    #1;
    check("async_out_valid", bus.out_valid, 0);
    check("async_err", err_count, 0);
    check("async_state", dbg_state, 0);
    exp_q.delete();
    exp_err = 0;
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    idle(1);
    check("ready_after_async", bus.in_ready, 1);
    send(1'b1, 4'b1000, 1'b0);
    idle(3);

    // Random traffic with random stalls and clears.
    rand_phase = 1;
    fork
      begin
        while (rand_phase) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join_none
    for (int i = 0; i < 300; i++) begin
      send($urandom_range(0, 7) != 0, N'($urandom_range(0, (1 << N) - 1)),
           $urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rand_phase = 0;
    idle(2);
    bus.out_ready = 1'b1;

    for (int t = 0; t < 200 && exp_q.size() != 0; t++) idle(1);
    check("final_drain", exp_q.size(), 0);
    idle(2);
    check("final_idle_valid", bus.out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
